// File: rtl/npu_pkg.sv
// Shared NPU definitions: layer mode codes, tile pad-type encodings and the
// depthwise tile scheduler state encoding.
package npu_pkg;

  localparam logic [3:0] DEPTH_CONV_MODE = 4'd6;

  localparam logic [1:0] TT_MID  = 2'b00;
  localparam logic [1:0] TT_TOP  = 2'b01;
  localparam logic [1:0] TT_BOT  = 2'b10;
  localparam logic [1:0] TT_BOTH = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/depthconv_tile_calc.sv
// Combinational per-tile parameter calculation: row count, first input row
// (clamped at the top pad) and the top/bottom pad classification.
module depthconv_tile_calc
  import npu_pkg::*;
#(
  parameter int ROW_W    = 8,
  parameter int IN_ROW_W = 10
) (
  input  logic [ROW_W-1:0]    out_y_length,
  input  logic [ROW_W-1:0]    tile_rows,
  input  logic [ROW_W-1:0]    row_start,
  input  logic [1:0]          stride,
  input  logic [1:0]          pad,
  output logic [ROW_W-1:0]    tile_out_rows,
  output logic [IN_ROW_W-1:0] in_row,
  output logic [1:0]          tilingtype
);

  logic [ROW_W-1:0]    remaining;
  logic [IN_ROW_W-1:0] scaled;
  logic [IN_ROW_W-1:0] pad_w;
  logic                first;
  logic                last;

  // NOTE: every combinational output is assigned on every path through the
  // block, so no latch can be inferred.
  always_comb begin
    remaining     = out_y_length - row_start;
    tile_out_rows = (tile_rows == '0 || tile_rows >= remaining) ? remaining : tile_rows;
    scaled        = IN_ROW_W'(row_start) * IN_ROW_W'(stride);
    pad_w         = IN_ROW_W'(pad);
    // The top tile starts inside the padding; its first real input row is 0.
    in_row        = (scaled < pad_w) ? '0 : scaled - pad_w;
    first         = (row_start == '0);
    last          = (tile_out_rows == remaining);
    tilingtype    = (pad == 2'd0) ? TT_MID : {last, first};
  end

endmodule

// File: rtl/depthconv_tile_scheduler.sv
// Splits one depthwise-convolution layer into output-row tiles and issues a
// start pulse plus registered tile parameters to the WAGU/IAGU for each tile.
module depthconv_tile_scheduler
  import npu_pkg::*;
#(
  parameter int ROW_W    = 8,
  parameter int IN_ROW_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_layer_valid,
  output logic                o_layer_ready,
  input  logic [3:0]          i_mode,
  input  logic [ROW_W-1:0]    i_out_y_length,
  input  logic [ROW_W-1:0]    i_tile_rows,
  input  logic [1:0]          i_stride,
  input  logic [1:0]          i_pad,
  input  logic                i_tile_done,
  input  logic                i_abort,
  output logic                o_start_calculate,
  output logic [1:0]          o_tilingtype,
  output logic [ROW_W-1:0]    o_tile_out_rows,
  output logic [IN_ROW_W-1:0] o_tile_in_row,
  output logic [ROW_W-1:0]    o_tile_idx,
  output logic                o_busy,
  output logic                o_layer_done
);

  sched_state_e state, next_state;

  logic [ROW_W-1:0]    lay_out_y;
  logic [ROW_W-1:0]    lay_tile_rows;
  logic [1:0]          lay_stride;
  logic [1:0]          lay_pad;
  logic [ROW_W-1:0]    row_start;
  logic                rst_done;

  logic [ROW_W-1:0]    calc_row_start;
  logic [ROW_W-1:0]    calc_rows;
  logic [IN_ROW_W-1:0] calc_in_row;
  logic [1:0]          calc_tt;
  logic                accept;
  logic                layer_end;

  assign accept = (state == S_IDLE) && i_layer_valid && o_layer_ready;

  // LOAD evaluates the first tile; NEXT evaluates the tile after the one just
  // finished, so the registered parameters are ready in the ISSUE cycle.
  always_comb begin
    calc_row_start = row_start;
    if (state == S_LOAD)      calc_row_start = '0;
    else if (state == S_NEXT) calc_row_start = row_start + o_tile_out_rows;
  end

  assign layer_end = (calc_row_start >= lay_out_y);

  depthconv_tile_calc #(
    .ROW_W    (ROW_W),
    .IN_ROW_W (IN_ROW_W)
  ) u_calc (
    .out_y_length  (lay_out_y),
    .tile_rows     (lay_tile_rows),
    .row_start     (calc_row_start),
    .stride        (lay_stride),
    .pad           (lay_pad),
    .tile_out_rows (calc_rows),
    .in_row        (calc_in_row),
    .tilingtype    (calc_tt)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (accept) next_state = S_LOAD;
      S_LOAD:  next_state = (lay_out_y == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (i_tile_done) next_state = S_NEXT;
      S_NEXT:  next_state = layer_end ? S_DONE : S_ISSUE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (state != S_IDLE && i_abort) next_state = S_IDLE;
  end

  // rst_done keeps ready low while reset is held, even with a valid mode pending.
  always_comb begin
    o_layer_ready     = (state == S_IDLE) && rst_done && (i_mode == DEPTH_CONV_MODE);
    o_start_calculate = (state == S_ISSUE);
    o_busy            = (state != S_IDLE);
    o_layer_done      = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_done        <= 1'b0;
      lay_out_y       <= '0;
      lay_tile_rows   <= '0;
      lay_stride      <= '0;
      lay_pad         <= '0;
      row_start       <= '0;
      o_tile_out_rows <= '0;
      o_tile_in_row   <= '0;
      o_tilingtype    <= TT_MID;
      o_tile_idx      <= '0;
    end else begin
      rst_done <= 1'b1;
      if (accept) begin
        lay_out_y     <= i_out_y_length;
        lay_tile_rows <= i_tile_rows;
        lay_stride    <= i_stride;
        lay_pad       <= i_pad;
      end
      if (next_state == S_ISSUE) begin
        row_start       <= calc_row_start;
        o_tile_out_rows <= calc_rows;
        o_tile_in_row   <= calc_in_row;
        o_tilingtype    <= calc_tt;
        o_tile_idx      <= (state == S_LOAD) ? '0 : o_tile_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_depthconv_tile_scheduler.sv
// Directed self-checking bench for depthconv_tile_scheduler: tile splitting,
// latency, stray inputs, mode filtering, abort and mid-layer reset.
module tb_depthconv_tile_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_layer_valid;
  logic       o_layer_ready;
  logic [3:0] i_mode;
  logic [7:0] i_out_y_length;
  logic [7:0] i_tile_rows;
  logic [1:0] i_stride;
  logic [1:0] i_pad;
  logic       i_tile_done;
  logic       i_abort;
  logic       o_start_calculate;
  logic [1:0] o_tilingtype;
  logic [7:0] o_tile_out_rows;
  logic [9:0] o_tile_in_row;
  logic [7:0] o_tile_idx;
  logic       o_busy;
  logic       o_layer_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  depthconv_tile_scheduler #(.ROW_W(8), .IN_ROW_W(10)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_layer_valid     (i_layer_valid),
    .o_layer_ready     (o_layer_ready),
    .i_mode            (i_mode),
    .i_out_y_length    (i_out_y_length),
    .i_tile_rows       (i_tile_rows),
    .i_stride          (i_stride),
    .i_pad             (i_pad),
    .i_tile_done       (i_tile_done),
    .i_abort           (i_abort),
    .o_start_calculate (o_start_calculate),
    .o_tilingtype      (o_tilingtype),
    .o_tile_out_rows   (o_tile_out_rows),
    .o_tile_in_row     (o_tile_in_row),
    .o_tile_idx        (o_tile_idx),
    .o_busy            (o_busy),
    .o_layer_done      (o_layer_done)
  );

  // Presents a descriptor at a falling edge, reports ready, and returns at the
  // falling edge of the cycle after the handshake edge (the LOAD cycle).
  task automatic send_layer(input logic [7:0] oy, input logic [7:0] tr,
                            input logic [1:0] s, input logic [1:0] p,
                            output logic rdy);
    @(negedge clk);
    i_mode = 4'd6; i_out_y_length = oy; i_tile_rows = tr; i_stride = s; i_pad = p;
    i_layer_valid = 1'b1;
    #1 rdy = o_layer_ready;
    @(negedge clk);
    i_layer_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget && n < 0; i++) begin
      @(negedge clk);
      if (o_start_calculate) n = i;
    end
  endtask

  task automatic wait_done(input int budget, output int n, output int starts);
    n = -1;
    starts = 0;
    for (int i = 1; i <= budget && n < 0; i++) begin
      @(negedge clk);
      if (o_start_calculate) starts++;
      if (o_layer_done) n = i;
    end
  endtask

  task automatic pulse_done();
    i_tile_done = 1'b1;
    @(negedge clk);
    i_tile_done = 1'b0;
  endtask

  function automatic logic [30:0] all_outs();
    return {o_layer_ready, o_start_calculate, o_busy, o_layer_done, o_tilingtype,
            o_tile_out_rows, o_tile_in_row, o_tile_idx[6:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    i_layer_valid = 1'b0; i_mode = 4'd6; i_out_y_length = '0; i_tile_rows = '0;
    i_stride = 2'd1; i_pad = '0; i_tile_done = 1'b0; i_abort = 1'b0;
    #12;
    tests++;
    if (all_outs() !== '0 || o_tile_idx !== '0) begin
      fails++; $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    tests++;
    if (o_layer_ready !== 1'b1 || o_busy !== 1'b0) begin
      fails++; $display("FAIL idle_ready got ready=%b busy=%b want 1/0", o_layer_ready, o_busy);
    end
  endtask

  // Runs a layer tile by tile and compares each tile against packed expectations.
  task automatic test_layer(input string name, input logic [7:0] oy, input logic [7:0] tr,
                            input logic [1:0] s, input logic [1:0] p, input int ntiles,
                            input logic [23:0] rows_v, input logic [29:0] in_v,
                            input logic [5:0] tt_v);
    logic rdy;
    int   n, starts;
    send_layer(oy, tr, s, p, rdy);
    tests++;
    if (rdy !== 1'b1) begin fails++; $display("FAIL %s handshake ready=%b want 1", name, rdy); end
    for (int k = 0; k < ntiles; k++) begin
      wait_start(4, n);
      tests++;
      if (n !== 1) begin fails++; $display("FAIL %s tile%0d start latency got %0d want 1", name, k, n); end
      tests++;
      if (o_tile_out_rows !== rows_v[k*8 +: 8] || o_tile_in_row !== in_v[k*10 +: 10] ||
          o_tilingtype !== tt_v[k*2 +: 2] || o_tile_idx !== 8'(k)) begin
        fails++;
        $display("FAIL %s tile%0d params got rows=%0d in=%0d tt=%b idx=%0d want rows=%0d in=%0d tt=%b idx=%0d",
                 name, k, o_tile_out_rows, o_tile_in_row, o_tilingtype, o_tile_idx,
                 rows_v[k*8 +: 8], in_v[k*10 +: 10], tt_v[k*2 +: 2], k);
      end
      if (k == 0) begin
        // tile_done during ISSUE must not be remembered
        i_tile_done = 1'b1;
        @(negedge clk);
        i_tile_done = 1'b0;
        wait_done(3, n, starts);
        tests++;
        if (starts !== 0 || n !== -1 || o_busy !== 1'b1) begin
          fails++; $display("FAIL %s stray_done got starts=%0d done=%0d busy=%b want 0/-1/1", name, starts, n, o_busy);
        end
      end else begin
        @(negedge clk);
      end
      tests++;
      if (o_tile_out_rows !== rows_v[k*8 +: 8] || o_start_calculate !== 1'b0) begin
        fails++; $display("FAIL %s tile%0d hold got rows=%0d start=%b want %0d/0", name, k,
                          o_tile_out_rows, o_start_calculate, rows_v[k*8 +: 8]);
      end
      pulse_done();
    end
    wait_done(4, n, starts);
    tests++;
    if (n !== 1 || starts !== 0) begin
      fails++; $display("FAIL %s layer_done latency got %0d starts=%0d want 1/0", name, n, starts);
    end
    @(negedge clk);
    tests++;
    if (o_layer_done !== 1'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL %s after_done got done=%b busy=%b want 0/0", name, o_layer_done, o_busy);
    end
  endtask

  task automatic test_zero_rows();
    logic rdy;
    int   n, starts;
    send_layer(8'd0, 8'd4, 2'd1, 2'd1, rdy);
    wait_done(4, n, starts);
    tests++;
    if (rdy !== 1'b1 || n !== 1 || starts !== 0) begin
      fails++; $display("FAIL zero_rows got ready=%b done_at=%0d starts=%0d want 1/1/0", rdy, n, starts);
    end
  endtask

  task automatic test_bad_mode();
    int n, starts;
    @(negedge clk);
    i_mode = 4'd1; i_out_y_length = 8'd4; i_tile_rows = 8'd2; i_layer_valid = 1'b1;
    #1;
    tests++;
    if (o_layer_ready !== 1'b0) begin fails++; $display("FAIL bad_mode ready got %b want 0", o_layer_ready); end
    wait_done(5, n, starts);
    tests++;
    if (n !== -1 || starts !== 0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL bad_mode activity got done=%0d starts=%0d busy=%b want -1/0/0", n, starts, o_busy);
    end
    i_layer_valid = 1'b0; i_mode = 4'd6;
  endtask

  task automatic test_abort();
    logic rdy;
    int   n, starts;
    send_layer(8'd10, 8'd4, 2'd1, 2'd1, rdy);
    wait_start(4, n);
    @(negedge clk);
    pulse_done();
    wait_start(4, n);
    tests++;
    if (n !== 1 || o_tile_idx !== 8'd1) begin
      fails++; $display("FAIL abort tile1 got latency=%0d idx=%0d want 1/1", n, o_tile_idx);
    end
    @(negedge clk);
    i_abort = 1'b1; i_tile_done = 1'b1;
    @(negedge clk);
    i_abort = 1'b0; i_tile_done = 1'b0;
    tests++;
    if (o_busy !== 1'b0) begin fails++; $display("FAIL abort idle busy got %b want 0", o_busy); end
    wait_done(6, n, starts);
    tests++;
    if (n !== -1 || starts !== 0) begin
      fails++; $display("FAIL abort quiet got done=%0d starts=%0d want -1/0", n, starts);
    end
    pulse_done();
    wait_done(5, n, starts);
    tests++;
    if (n !== -1 || starts !== 0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL abort late_done got done=%0d starts=%0d busy=%b want -1/0/0", n, starts, o_busy);
    end
  endtask

  task automatic test_reset_midlayer();
    logic rdy;
    int   n;
    send_layer(8'd10, 8'd4, 2'd1, 2'd1, rdy);
    wait_start(4, n);
    tests++;
    if (n !== 1) begin fails++; $display("FAIL midreset issue latency got %0d want 1", n); end
    #2 rst = 1'b0;
    #1;
    tests++;
    if (all_outs() !== '0 || o_tile_idx !== '0) begin
      fails++; $display("FAIL midreset outputs got %h want 0", all_outs());
    end
    @(negedge clk);
    rst = 1'b1;
    test_layer("after_reset", 8'd6, 8'd3, 2'd2, 2'd0, 2,
               {8'd0, 8'd3, 8'd3}, {10'd0, 10'd6, 10'd0}, {2'b00, 2'b00, 2'b00});
  endtask

  initial begin
    test_reset();
    test_layer("rows10_tile4", 8'd10, 8'd4, 2'd1, 2'd1, 3,
               {8'd2, 8'd4, 8'd4}, {10'd7, 10'd3, 10'd0}, {2'b10, 2'b00, 2'b01});
    test_layer("rows5_tile8", 8'd5, 8'd8, 2'd1, 2'd1, 1,
               {8'd0, 8'd0, 8'd5}, {10'd0, 10'd0, 10'd0}, {2'b00, 2'b00, 2'b11});
    test_layer("stride2_nopad", 8'd6, 8'd3, 2'd2, 2'd0, 2,
               {8'd0, 8'd3, 8'd3}, {10'd0, 10'd6, 10'd0}, {2'b00, 2'b00, 2'b00});
    test_zero_rows();
    test_bad_mode();
    test_abort();
    test_reset_midlayer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
